// File: rtl/ray_generator.sv
`default_nettype none
// ============================================================================
//  Module   : ray_generator
//  Purpose  : Walks an H_RES x V_RES pixel grid and emits one unnormalised
//             Q16.16 primary ray per pixel on a valid/ready handshake.
//  Revision : 1.0  initial release
// ============================================================================
module ray_generator #(
    parameter int H_RES = 64,
    parameter int V_RES = 48,
    parameter int CW    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic signed [31:0] cam_pos [2:0],
    input  logic signed [31:0] corner_x,
    input  logic signed [31:0] corner_y,
    input  logic signed [31:0] focal,
    input  logic signed [31:0] step,
    output logic signed [31:0] ray_origin [2:0],
    output logic signed [31:0] ray_dir [2:0],
    output logic [CW-1:0]      pix_x,
    output logic [CW-1:0]      pix_y,
    output logic               ray_last,
    output logic               ray_valid,
    input  logic               ray_ready,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CW-1:0] c_last_x = CW'(H_RES - 1);
    localparam logic [CW-1:0] c_last_y = CW'(V_RES - 1);
    localparam logic [CW-1:0] c_one    = {{(CW-1){1'b0}}, 1'b1};

    state_t             r_state;
    state_t             w_state_nxt;
    logic signed [31:0] r_origin [2:0];
    logic signed [31:0] r_corner_x;
    logic signed [31:0] r_focal;
    logic signed [31:0] r_step;
    logic signed [31:0] r_dir_x;
    logic signed [31:0] r_dir_y;
    logic [CW-1:0]      r_pix_x;
    logic [CW-1:0]      r_pix_y;
    logic               w_launch;
    logic               w_xfer;
    logic               w_row_end;
    logic               w_at_last;

    assign w_launch  = (r_state == S_IDLE) && start;
    assign w_xfer    = (r_state == S_RUN) && ray_ready;
    assign w_row_end = (r_pix_x == c_last_x);
    assign w_at_last = w_row_end && (r_pix_y == c_last_y);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        ray_valid   = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        ray_last    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                ray_valid = 1'b1;
                busy      = 1'b1;
                ray_last  = w_at_last;
                if (ray_ready && w_at_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Directions advance by addition only; the final transfer leaves the
    // fields on the last ray instead of stepping past the grid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                r_origin[i] <= '0;
            end
            r_corner_x <= '0;
            r_focal    <= '0;
            r_step     <= '0;
            r_dir_x    <= '0;
            r_dir_y    <= '0;
            r_pix_x    <= '0;
            r_pix_y    <= '0;
        end else if (w_launch) begin
            for (int i = 0; i < 3; i++) begin
                r_origin[i] <= cam_pos[i];
            end
            r_corner_x <= corner_x;
            r_focal    <= focal;
            r_step     <= step;
            r_dir_x    <= corner_x;
            r_dir_y    <= corner_y;
            r_pix_x    <= '0;
            r_pix_y    <= '0;
        end else if (w_xfer && !w_at_last) begin
            if (!w_row_end) begin
                r_pix_x <= r_pix_x + c_one;
                r_dir_x <= r_dir_x + r_step;
            end else begin
                r_pix_x <= '0;
                r_dir_x <= r_corner_x;
                r_pix_y <= r_pix_y + c_one;
                r_dir_y <= r_dir_y - r_step;
            end
        end
    end

    assign ray_origin[0] = r_origin[0];
    assign ray_origin[1] = r_origin[1];
    assign ray_origin[2] = r_origin[2];
    assign ray_dir[0]    = r_dir_x;
    assign ray_dir[1]    = r_dir_y;
    assign ray_dir[2]    = r_focal;
    assign pix_x         = r_pix_x;
    assign pix_y         = r_pix_y;

endmodule
`default_nettype wire

// File: doc/ray_generator.md
Name: ray_generator

Overview:
- Sequential ray source for the ray-plane intersection stage: it walks a pixel grid and emits one primary ray per pixel.
- Each ray is a camera origin plus an unnormalised direction, all in signed Q16.16, delivered on a valid/ready handshake.
- Direction vectors are built incrementally by adders, with no multipliers. The downstream intersector performs its own divide, so directions are not normalised.

Parameters:
- H_RES, 64, pixels per row (x range 0..H_RES-1), must be >= 1
- V_RES, 48, rows per frame (y range 0..V_RES-1), must be >= 1
- CW, 16, width of the pixel coordinate counters; must satisfy 2^CW >= max(H_RES, V_RES)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle frame request; honoured only in IDLE
- cam_pos  input  signed 32 [2:0]  camera origin x/y/z, Q16.16
- corner_x  input  signed 32  direction x of pixel (0,y), Q16.16
- corner_y  input  signed 32  direction y of pixel (x,0), Q16.16
- focal  input  signed 32  direction z, constant for all rays, Q16.16
- step  input  signed 32  per-pixel increment, Q16.16
- ray_origin  output  signed 32 [2:0]  origin of the current ray
- ray_dir  output  signed 32 [2:0]  direction of the current ray
- pix_x  output  CW  x coordinate of the current ray
- pix_y  output  CW  y coordinate of the current ray
- ray_last  output  1  high with the final ray of the frame
- ray_valid  output  1  ray fields are valid
- ray_ready  input  1  downstream accepts the ray
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse after the last ray transfers

Behaviour:
- States: IDLE, RUN, DONE. Reset forces IDLE asynchronously.
- Reset values: every output is 0, including all ray fields, pix_x, pix_y, ray_last, ray_valid, busy and done.
- IDLE with start=1:
  - Latch cam_pos, corner_x, corner_y, focal and step.
  - Next cycle: RUN, ray_valid=1, pix=(0,0), ray_dir=(corner_x, corner_y, focal), ray_origin=cam_pos.
  - Latency from the start edge to the first valid ray is 1 cycle.
- Latched configuration is fixed for the whole frame. Input changes during RUN or DONE have no effect.
- start while busy or in DONE is ignored.
- Transfer occurs on any cycle with ray_valid && ray_ready. On a transfer the next ray appears the following cycle, giving full throughput of 1 ray/cycle under continuous ready.
- When ray_valid=1 and ray_ready=0, all ray outputs, pix_x/pix_y and ray_last hold stable.
- ray_valid never drops in RUN without a transfer.
- Advance on transfer:
  - If pix_x < H_RES-1: pix_x+1 and dir_x += step.
  - Otherwise: pix_x=0, dir_x=corner_x, pix_y+1, dir_y -= step. Rows descend.
- Resulting direction for pixel (x,y): dir_x = corner_x + x*step, dir_y = corner_y - y*step, dir_z = focal.
- Arithmetic is 32-bit two's complement, wrap-around, with no saturation or overflow flag.
- ray_last=1 exactly when pix_x=H_RES-1 and pix_y=V_RES-1 with ray_valid=1.
- H_RES=V_RES=1: the first ray has ray_last=1.
- Transfer with ray_last=1:
  - Next cycle: DONE, ray_valid=0, ray_last=0, busy=0, done=1.
  - Following cycle: IDLE, done=0.
  - A start asserted in the DONE cycle is dropped.
- busy=1 in every RUN cycle, including stalled cycles.
- Ray fields after the frame retain their last values; consumers gate on ray_valid only.
- rst_n low mid-frame: immediate return to IDLE with all outputs 0. No partial frame is resumed; a new start is required.

Test Plan:
- Basic frame, H_RES=4, V_RES=2, corner_x=0xFFFE0000, corner_y=0x00010000, step=0x00008000, focal=0x00010000, cam_pos=(1,2,3)<<16, ready held 1, start pulse:
  - 8 rays on 8 consecutive cycles starting 1 cycle after start.
  - ray0 dir=(FFFE0000,00010000,00010000); ray3 dir_x=FFFF8000; ray4 dir=(FFFE0000,00008000,00010000).
  - ray7 has ray_last=1; done=1 on the next cycle; origin=(00010000,00020000,00030000) throughout.
- Backpressure, same config, ray_ready=0 for cycles 3-6 after start:
  - ray2 fields and pix=(2,0) held stable with valid=1 for the whole stall.
  - Sequence resumes with ray3 without skipping or duplicating.
  - Total of 8 transfers.
- Ignored start and frozen config:
  - start pulsed during RUN and again in the DONE cycle: no restart; done pulses once; returns to IDLE.
  - corner_x changed mid-frame: no effect on emitted dirs.
- Reset mid-frame: rst_n low after 3 transfers -> valid, busy and all fields 0 within the same cycle. A new start restarts at pix=(0,0).
- Wrap and degenerate size:
  - H_RES=V_RES=1: single ray with ray_last=1, done next cycle.
  - corner_x=0x7FFF0000, step=0x00010000, H_RES=2: ray1 dir_x=0x80000000 (wrap, no saturation).
